// File: rtl/ifu_pkg.sv
// Shared constants, FSM state encoding and instruction field layout for the fetch unit.
// The end-of-program zero-word detection is controlled by macro IFU_ZERO_HALT_EN.
package ifu_pkg;

    localparam int IFU_AW = 6;
    localparam int IFU_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic       flag;
        logic [5:0] ra;
        logic [5:0] rb;
        logic [3:0] opcode;
        logic [5:0] rd;
        logic [8:0] imm;
    } instr_t;

    // An all-zero word marks the end of the program image.
    function automatic logic is_end_word(input logic [IFU_DW-1:0] word);
        return (word == {IFU_DW{1'b0}});
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Program counter register: load a target, increment modulo 2^AW, or hold.
module ifu_pc_reg #(
    parameter int            AW        = 6,
    parameter logic [AW-1:0] RESET_VAL = 6'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_value,
    input  logic          inc_en,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_r;

    // PC update; load wins over increment, wrap on overflow is intentional.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_VAL;
        end else if (load_en) begin
            pc_r <= load_value;
        end else if (inc_en) begin
            pc_r <= pc_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/HALT FSM with valid/ready output register and branch flush.
// Define IFU_ZERO_HALT_EN to halt on an all-zero instruction word.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int            AW       = IFU_AW,
    parameter int            DW       = IFU_DW,
    parameter logic [AW-1:0] START_PC = 6'd0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] imem_address,
    input  logic [DW-1:0] imem_read_data,
    input  logic          branch_en,
    input  logic [AW-1:0] branch_target,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [AW-1:0] pc,
    output logic          halted
);

    ifu_state_e    state_r, next_state_s;
    logic [DW-1:0] instr_r;
    logic [AW-1:0] instr_pc_r;
    logic          instr_valid_r;
    logic          load_s, flush_s, halt_s, stop_word_s;
    logic          pc_load_s, pc_inc_s;
    logic [AW-1:0] pc_load_value_s;

`ifdef IFU_ZERO_HALT_EN
    assign stop_word_s = is_end_word(imem_read_data);
`else
    assign stop_word_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and fetch control; branch beats both load and backpressure.
    always_comb begin
        next_state_s    = state_r;
        load_s          = 1'b0;
        flush_s         = 1'b0;
        halt_s          = 1'b0;
        pc_load_s       = 1'b0;
        pc_load_value_s = START_PC;
        pc_inc_s        = 1'b0;
        case (state_r)
            IDLE, HALT: begin
                if (start) begin
                    next_state_s = FETCH;
                    pc_load_s    = 1'b1;
                end else begin
                    next_state_s = state_r;
                end
            end
            FETCH: begin
                if (branch_en) begin
                    flush_s         = 1'b1;
                    pc_load_s       = 1'b1;
                    pc_load_value_s = branch_target;
                end else if (!instr_valid_r || instr_ready) begin
                    if (stop_word_s) begin
                        halt_s       = 1'b1;
                        next_state_s = HALT;
                    end else begin
                        load_s   = 1'b1;
                        pc_inc_s = 1'b1;
                    end
                end else begin
                    next_state_s = FETCH;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output instruction register; held under backpressure, cleared on flush/halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r       <= {DW{1'b0}};
            instr_pc_r    <= {AW{1'b0}};
            instr_valid_r <= 1'b0;
        end else if (load_s) begin
            instr_r       <= imem_read_data;
            instr_pc_r    <= pc;
            instr_valid_r <= 1'b1;
        end else if (flush_s || halt_s || (state_r == HALT)) begin
            instr_valid_r <= 1'b0;
        end else begin
            instr_valid_r <= instr_valid_r;
        end
    end

`ifdef IFU_ZERO_HALT_EN
    logic halted_r;

    // Halt flag tracks entry into and exit from HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r <= 1'b0;
        end else begin
            halted_r <= (next_state_s == HALT);
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    ifu_pc_reg #(
        .AW        (AW),
        .RESET_VAL (START_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (pc_load_s),
        .load_value (pc_load_value_s),
        .inc_en     (pc_inc_s),
        .pc         (pc)
    );

    assign imem_address = pc;
    assign instr        = instr_r;
    assign instr_pc     = instr_pc_r;
    assign instr_valid  = instr_valid_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a combinational model memory.
// Covers the IFU_ZERO_HALT_EN build or the default build depending on the macro.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  imem_address;
    logic [31:0] imem_read_data;
    logic        branch_en;
    logic [5:0]  branch_target;
    logic [31:0] instr;
    logic [5:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_read_data = (imem_address <= 6'd20) ? (32'h1000_0000 | {26'd0, imem_address}) : 32'h0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .imem_address   (imem_address),
        .imem_read_data (imem_read_data),
        .branch_en      (branch_en),
        .branch_target  (branch_target),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .pc             (pc),
        .halted         (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_instr(input string tag, input logic [5:0] exp_pc_of_instr,
                               input logic [31:0] exp_word, input logic [5:0] exp_next_pc);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_ipc"}, {26'd0, instr_pc}, {26'd0, exp_pc_of_instr});
        check({tag, "_instr"}, instr, exp_word);
        check({tag, "_pc"}, {26'd0, pc}, {26'd0, exp_next_pc});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; branch_en = 1'b0; branch_target = 6'd0; instr_ready = 1'b0;
        #2;
        check("rst_pc", {26'd0, pc}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_ipc", {26'd0, instr_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();
        check("idle_valid", {31'd0, instr_valid}, 32'd0);

        // Start, full-rate stream
        instr_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("start_c1_valid", {31'd0, instr_valid}, 32'd0);
        check("start_c1_pc", {26'd0, pc}, 32'd0);
        step();
        check_instr("first", 6'd0, 32'h1000_0000, 6'd1);
        for (int n = 1; n <= 5; n++) begin
            step();
            check_instr("stream", 6'(n), 32'h1000_0000 | n, 6'(n + 1));
        end

        // Backpressure at instr_pc=5
        instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_instr("stall", 6'd5, 32'h1000_0005, 6'd6);
        end
        instr_ready = 1'b1;
        step();
        check_instr("resume", 6'd6, 32'h1000_0006, 6'd7);

        // Branch beats backpressure
        instr_ready = 1'b0; branch_en = 1'b1; branch_target = 6'd12;
        step();
        branch_en = 1'b0; instr_ready = 1'b1;
        check("br_flush_valid", {31'd0, instr_valid}, 32'd0);
        check("br_flush_pc", {26'd0, pc}, 32'd12);
        step();
        check_instr("br_target", 6'd12, 32'h1000_000C, 6'd13);

        // Start during FETCH is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        check_instr("start_ignored", 6'd13, 32'h1000_000D, 6'd14);

`ifdef IFU_ZERO_HALT_EN
        for (int n = 14; n <= 20; n++) begin
            step();
            check_instr("to_end", 6'(n), 32'h1000_0000 | n, 6'(n + 1));
        end
        step();
        check("halt_halted", {31'd0, halted}, 32'd1);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_pc", {26'd0, pc}, 32'd21);
        branch_en = 1'b1; branch_target = 6'd3;
        step();
        branch_en = 1'b0;
        check("halt_br_pc", {26'd0, pc}, 32'd21);
        check("halt_br_halted", {31'd0, halted}, 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_halted", {31'd0, halted}, 32'd0);
        check("restart_pc", {26'd0, pc}, 32'd0);
        check("restart_valid", {31'd0, instr_valid}, 32'd0);
        step();
        check_instr("restart_first", 6'd0, 32'h1000_0000, 6'd1);
`else
        // Wraparound through zero words; no halting in this build
        branch_en = 1'b1; branch_target = 6'd62;
        step();
        branch_en = 1'b0;
        check("wrap_flush_valid", {31'd0, instr_valid}, 32'd0);
        check("wrap_flush_pc", {26'd0, pc}, 32'd62);
        step();
        check_instr("wrap62", 6'd62, 32'h0, 6'd63);
        check("wrap62_halted", {31'd0, halted}, 32'd0);
        step();
        check_instr("wrap63", 6'd63, 32'h0, 6'd0);
        step();
        check_instr("wrap0", 6'd0, 32'h1000_0000, 6'd1);
        check("wrap0_halted", {31'd0, halted}, 32'd0);
`endif

        // Asynchronous reset mid-stream
        check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, instr_valid}, 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_ipc", {26'd0, instr_pc}, 32'd0);
        check("arst_pc", {26'd0, pc}, 32'd0);
        check("arst_halted", {31'd0, halted}, 32'd0);
        #3;
        rst_n = 1'b1;
        branch_en = 1'b1; branch_target = 6'd9;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
            check("post_rst_pc", {26'd0, pc}, 32'd0);
        end
        branch_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be: AW, 6, instruction-memory address width; DW, 32, instruction word width; START_PC, 6'd0, PC after reset and on restart.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-low reset; the ports SHALL be clk and rst_n.
REQ-003 Ports SHALL be:
- clk, input, 1, clock, all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, leave IDLE/HALT and begin fetching at START_PC.
- imem_address, output, AW, address to instruction memory; equals pc combinationally.
- imem_read_data, input, DW, combinational read data from instruction memory.
- branch_en, input, 1, redirect fetch this cycle.
- branch_target, input, AW, redirect address.
- instr, output, DW, registered instruction to decoder.
- instr_pc, output, AW, address that instr was fetched from.
- instr_valid, output, 1, instr/instr_pc hold a live instruction.
- instr_ready, input, 1, decoder accepts instr this cycle.
- pc, output, AW, next fetch address.
- halted, output, 1, FSM in HALT.

Function
REQ-004 FSM states SHALL be IDLE, FETCH, HALT.
REQ-005 IDLE: no loads; start=1 -> FETCH next cycle, pc<=START_PC.
REQ-006 FETCH load condition SHALL be (!instr_valid || instr_ready) && !branch_en.
- On load: instr<=imem_read_data, instr_pc<=pc, instr_valid<=1, pc<=pc+1.
REQ-007 Throughput SHALL be one instruction per cycle while instr_ready=1; latency from pc to instr SHALL be exactly 1 cycle.
REQ-008 Backpressure: instr_valid=1 && instr_ready=0 SHALL hold instr, instr_pc, instr_valid and pc unchanged.
REQ-009 Branch in FETCH: pc<=branch_target, instr_valid<=0 (flush), no load that cycle; branch_en SHALL take priority over load and over backpressure.
REQ-010 Branch SHALL be ignored in IDLE and HALT.
REQ-011 pc arithmetic SHALL be modulo 2^AW: 63+1 -> 0, no flag.
REQ-012 Handshake transfer SHALL occur when instr_valid && instr_ready at a rising edge; instr SHALL never change while instr_valid=1 and instr_ready=0, except for a branch flush.
REQ-013 HALT: instr_valid<=0, halted=1; start=1 -> FETCH with pc<=START_PC.
REQ-014 start while in FETCH SHALL be ignored.

Reset
REQ-015 rst_n=0 SHALL asynchronously force: state=IDLE, pc=START_PC, instr=0, instr_pc=0, instr_valid=0, halted=0.
REQ-016 Reset mid-transfer SHALL discard the held instruction; no partial state SHALL survive.

Configuration
REQ-017 Macro IFU_ZERO_HALT_EN SHALL control end-of-program detection.
- Defined: a load whose imem_read_data==32'h0 SHALL instead leave instr_valid=0, leave pc unchanged, and enter HALT.
- Undefined: zero words SHALL be issued as normal instructions, HALT SHALL be unreachable, and halted SHALL be tied 0.

Structure
REQ-018 Shared package ifu_pkg SHALL hold AW/DW constants, the state enum, and packed struct instr_t. Field layout, MSB first: flag[1], ra[6], rb[6], opcode[4], rd[6], imm[9].
REQ-019 Sub-module ifu_pc_reg SHALL hold pc with load-target, increment and hold controls; all other logic SHALL be in instr_fetch_unit.

Verification
REQ-020 The bench model memory SHALL hold: word[i]=32'h1000_0000|i for i=0..20, and 0 for i>=21.
REQ-021 Scenarios the bench SHALL cover:
- Reset, start pulse, instr_ready=1 -> instr_pc 0,1,2… on consecutive cycles, instr=32'h1000_0000|n, first valid 2 cycles after start.
- instr_ready=0 for 3 cycles while instr_pc=5 -> instr, instr_pc=5 and pc=6 stable; transfer resumes with instr_pc=6.
- branch_en=1, branch_target=12, while instr_ready=0 -> next cycle instr_valid=0, pc=12; the following instruction has instr_pc=12.
- IFU_ZERO_HALT_EN defined, run from 0 -> last transfer instr_pc=20, then halted=1, instr_valid=0, pc=21; start -> restart at 0.
- IFU_ZERO_HALT_EN undefined, branch to 62 -> instr_pc sequence 62,63,0 with zero words issued, halted=0.
- rst_n low asynchronously mid-stream with instr_valid=1 -> outputs immediately reach reset values; no transfer after release until start.
